// File: rtl/pll_pkg.sv
// pll_pkg: constants and helpers shared by the PLL stimulus and measurement
// blocks (sweep_gen, nco, freq_counter).
//   CLK_HZ    - sys_clk frequency in Hz
//   TW_SCALE  - round(2^48 / CLK_HZ); tuning word = (f_hz * TW_SCALE) >> 16
//   ACC_W     - phase accumulator width; square wave is the accumulator MSB
//   FREQ_W    - width of frequency values in Hz
//   sweep_state_t - sweep FSM encoding
//   freq_to_tw    - Hz to tuning word, saturated to just below half the clock
package pll_pkg;

  localparam int unsigned    CLK_HZ   = 50_000_000;
  localparam logic [63:0]    TW_SCALE = 64'd5_629_500;
  localparam int             ACC_W    = 32;
  localparam int             FREQ_W   = 32;

  // Largest tuning word that still yields a clean square wave (MSB toggles
  // at most once per clock).
  localparam logic [63:0]    TW_MAX   = (64'd1 << (ACC_W - 1)) - 64'd1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  function automatic logic [ACC_W-1:0] freq_to_tw(input logic [FREQ_W-1:0] f_hz);
    logic [63:0] prod;
    logic [63:0] shifted;
    prod    = {{(64-FREQ_W){1'b0}}, f_hz} * TW_SCALE;
    shifted = prod >> 16;
    if (shifted > TW_MAX) begin
      return TW_MAX[ACC_W-1:0];
    end
    return shifted[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/sweep_tw_calc.sv
// sweep_tw_calc: registered frequency-to-tuning-word conversion, 1-cycle latency.
//   clk    in   system clock
//   reset  in   synchronous, active-high; clears tw
//   f_hz   in   requested frequency in Hz
//   tw     out  phase increment per clock, saturated to 2^(ACC_W-1)-1
module sweep_tw_calc
  import pll_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [FREQ_W-1:0] f_hz,
  output logic [ACC_W-1:0]  tw
);

  always_ff @(posedge clk) begin
    if (reset) begin
      tw <= '0;
    end else begin
      tw <= freq_to_tw(f_hz);
    end
  end

endmodule

// File: rtl/sweep_gen.sv
// sweep_gen: phase-accumulator square-wave source that steps its frequency
// from f_start to f_stop in f_step increments, holding each step for dwell
// clocks. The accumulator never pauses while running, so the output is
// phase-continuous across frequency steps.
//
// Handshake: start is a 1-cycle request accepted only in IDLE (and only when
// abort is low); busy is high while the request is being served (LOAD/RUN);
// done pulses for one cycle when a sweep ends normally. abort is a level that
// returns the block to IDLE on the next edge without a done pulse.
//
//   sys_clk    in   system clock
//   reset      in   synchronous, active-high
//   start      in   1-cycle pulse; latches sweep parameters
//   abort      in   level; ends a sweep next cycle, no done
//   f_start    in   first frequency, Hz
//   f_stop     in   last allowed frequency, Hz (inclusive)
//   f_step     in   increment, Hz; 0 = continuous tone at f_start
//   dwell      in   clocks per step; 0 treated as 1
//   A          out  generated square wave (accumulator MSB)
//   cur_freq   out  frequency currently commanded, Hz
//   busy       out  high in LOAD/RUN
//   done       out  1-cycle pulse at normal sweep end
//   step_tick  out  1-cycle pulse when cur_freq advances
//   fsm_state  out  current FSM state, for observation
module sweep_gen
  import pll_pkg::*;
(
  input  logic              sys_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [FREQ_W-1:0] f_start,
  input  logic [FREQ_W-1:0] f_stop,
  input  logic [FREQ_W-1:0] f_step,
  input  logic [31:0]       dwell,
  output logic              A,
  output logic [FREQ_W-1:0] cur_freq,
  output logic              busy,
  output logic              done,
  output logic              step_tick,
  output sweep_state_t      fsm_state
);

  sweep_state_t      state;
  sweep_state_t      next_state;

  logic [FREQ_W-1:0] f_stop_q;
  logic [FREQ_W-1:0] f_step_q;
  logic [31:0]       dwell_q;
  logic [31:0]       dwell_cnt;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  tw;

  logic              accept;
  logic              dwell_end;
  logic [FREQ_W:0]   nxt_freq;
  logic              past_stop;

  // tw follows cur_freq one cycle later; LOAD exists so the first RUN cycle
  // already sees the tuning word for f_start.
  sweep_tw_calc u_tw (
    .clk   (sys_clk),
    .reset (reset),
    .f_hz  (cur_freq),
    .tw    (tw)
  );

  assign accept    = start && !abort;
  assign dwell_end = (dwell_cnt == dwell_q - 32'd1);
  // One extra bit so a step past 2^32-1 is seen as overflow, not a wrap.
  assign nxt_freq  = {1'b0, cur_freq} + {1'b0, f_step_q};
  assign past_stop = nxt_freq[FREQ_W] || (nxt_freq[FREQ_W-1:0] > f_stop_q);

  assign A         = acc[ACC_W-1];
  assign fsm_state = state;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    step_tick  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) next_state = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        next_state = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          next_state = IDLE;
        end else if (dwell_end && (f_step_q != '0)) begin
          if (past_stop) next_state = DONE;
          else           step_tick  = 1'b1;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cur_freq  <= '0;
      f_stop_q  <= '0;
      f_step_q  <= '0;
      dwell_q   <= '0;
      dwell_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          acc       <= '0;
          dwell_cnt <= '0;
          if (accept) begin
            cur_freq <= f_start;
            f_stop_q <= f_stop;
            f_step_q <= f_step;
            dwell_q  <= (dwell == 32'd0) ? 32'd1 : dwell;
          end
        end
        LOAD: begin
          dwell_cnt <= '0;
          if (abort) acc <= '0;
        end
        RUN: begin
          if (abort) begin
            acc       <= '0;
            dwell_cnt <= '0;
          end else begin
            acc <= acc + tw;
            if (dwell_end) dwell_cnt <= '0;
            else           dwell_cnt <= dwell_cnt + 32'd1;
            if (step_tick) cur_freq <= nxt_freq[FREQ_W-1:0];
          end
        end
        DONE: begin
          acc       <= '0;
          dwell_cnt <= '0;
        end
        default: begin
          acc       <= '0;
          dwell_cnt <= '0;
        end
      endcase
    end
  end

endmodule
